// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg : shared encodings for the multicycle ARM control unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] c_alu_add = 2'b00;
  localparam logic [1:0] c_alu_sub = 2'b01;
  localparam logic [1:0] c_alu_and = 2'b10;
  localparam logic [1:0] c_alu_orr = 2'b11;

  localparam logic [1:0] c_op_dp  = 2'b00;
  localparam logic [1:0] c_op_mem = 2'b01;
  localparam logic [1:0] c_op_br  = 2'b10;

  localparam logic [1:0] c_res_aluout    = 2'd0;
  localparam logic [1:0] c_res_data      = 2'd1;
  localparam logic [1:0] c_res_aluresult = 2'd2;

  localparam logic [1:0] c_srcb_rd2    = 2'd0;
  localparam logic [1:0] c_srcb_extimm = 2'd1;
  localparam logic [1:0] c_srcb_four   = 2'd2;

  localparam logic [3:0] c_cond_eq = 4'b0000;
  localparam logic [3:0] c_cond_ne = 4'b0001;
  localparam logic [3:0] c_cond_cs = 4'b0010;
  localparam logic [3:0] c_cond_cc = 4'b0011;
  localparam logic [3:0] c_cond_mi = 4'b0100;
  localparam logic [3:0] c_cond_pl = 4'b0101;
  localparam logic [3:0] c_cond_vs = 4'b0110;
  localparam logic [3:0] c_cond_vc = 4'b0111;
  localparam logic [3:0] c_cond_hi = 4'b1000;
  localparam logic [3:0] c_cond_ls = 4'b1001;
  localparam logic [3:0] c_cond_ge = 4'b1010;
  localparam logic [3:0] c_cond_lt = 4'b1011;
  localparam logic [3:0] c_cond_gt = 4'b1100;
  localparam logic [3:0] c_cond_le = 4'b1101;
  localparam logic [3:0] c_cond_al = 4'b1110;

  // Raw (ungated) per-state control bundle
  typedef struct packed {
    logic       nextpc;
    logic       irwrite;
    logic       adrsrc;
    logic       memw;
    logic       regw;
    logic       alusrca;
    logic       aluop;
    logic       branch;
    logic [1:0] resultsrc;
    logic [1:0] alusrcb;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = c_srcb_four;
        c.resultsrc = c_res_aluresult;
        c.nextpc    = 1'b1;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = c_srcb_four;
        c.resultsrc = c_res_aluresult;
      end
      MEMADR:   c.alusrcb = c_srcb_extimm;
      MEMREAD:  c.adrsrc  = 1'b1;
      MEMWB: begin
        c.resultsrc = c_res_data;
        c.regw      = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      EXECUTER: c.aluop = 1'b1;
      EXECUTEI: begin
        c.alusrcb = c_srcb_extimm;
        c.aluop   = 1'b1;
      end
      ALUWB:    c.regw = 1'b1;
      BRANCH: begin
        c.alusrcb   = c_srcb_extimm;
        c.resultsrc = c_res_aluresult;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit : NZCV flags register, condition evaluation and held CondExR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  input  logic       capture,
  output logic       condexr
);

  logic [3:0] r_flags;
  logic       r_condexr;
  logic       w_condex;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condex = 1'b0;
    case (cond)
      c_cond_eq: w_condex = w_z;
      c_cond_ne: w_condex = ~w_z;
      c_cond_cs: w_condex = w_c;
      c_cond_cc: w_condex = ~w_c;
      c_cond_mi: w_condex = w_n;
      c_cond_pl: w_condex = ~w_n;
      c_cond_vs: w_condex = w_v;
      c_cond_vc: w_condex = ~w_v;
      c_cond_hi: w_condex = w_c & ~w_z;
      c_cond_ls: w_condex = ~w_c | w_z;
      c_cond_ge: w_condex = (w_n == w_v);
      c_cond_lt: w_condex = (w_n != w_v);
      c_cond_gt: w_condex = ~w_z & (w_n == w_v);
      c_cond_le: w_condex = w_z | (w_n != w_v);
      c_cond_al: w_condex = 1'b1;
      default:   w_condex = 1'b0;
    endcase
  end

  // CondExR is frozen after DECODE so an execute-stage flag write cannot gate its own writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags   <= 4'b0000;
      r_condexr <= 1'b0;
    end else begin
      if (capture)
        r_condexr <= w_condex;
      if (flagw[1] & r_condexr)
        r_flags[3:2] <= aluflags[3:2];
      if (flagw[0] & r_condexr)
        r_flags[1:0] <= aluflags[1:0];
    end
  end

  assign condexr = r_condexr;

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl : instruction-step FSM, ALU decoder and strobe gating for
// the multicycle ARM datapath. Optional retired counter: CTRL_PERF_CNT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Instr,
  input  logic [3:0]            ALUFlags,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ALUControl,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [3:0]            State
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  RetiredCount
`endif
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic [3:0] w_cond;
  logic [1:0] w_alu;
  logic [1:0] w_flagw;
  logic       w_pcs;
  logic       w_condexr;
  logic       w_unused;

  assign w_cond   = Instr[31:28];
  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_rd     = Instr[15:12];
  assign w_unused = ^{Instr[19:16], Instr[11:0]};

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (w_op)
          c_op_mem: w_next = MEMADR;
          c_op_dp:  w_next = w_funct[5] ? EXECUTEI : EXECUTER;
          c_op_br:  w_next = BRANCH;
          default:  w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = w_funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  // Control bundle is decoded from the next state so it is registered alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_ctrl  <= state_ctrl(FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  always_comb begin
    w_alu = c_alu_add;
    if (r_ctrl.aluop) begin
      case (w_funct[4:1])
        4'b0100: w_alu = c_alu_add;
        4'b0010: w_alu = c_alu_sub;
        4'b0000: w_alu = c_alu_and;
        4'b1100: w_alu = c_alu_orr;
        default: w_alu = c_alu_add;
      endcase
    end
  end

  assign w_flagw[1] = r_ctrl.aluop & w_funct[0];
  assign w_flagw[0] = w_flagw[1] & ((w_alu == c_alu_add) | (w_alu == c_alu_sub));

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (w_cond),
    .aluflags (ALUFlags),
    .flagw    (w_flagw),
    .capture  (r_state == DECODE),
    .condexr  (w_condexr)
  );

  assign w_pcs = r_ctrl.regw & (w_rd == 4'hf);

  // Strobes are held low while reset is asserted, including the FETCH defaults
  assign PCWrite    = reset & (r_ctrl.nextpc | ((r_ctrl.branch | w_pcs) & w_condexr));
  assign IRWrite    = reset & r_ctrl.irwrite;
  assign RegWrite   = reset & r_ctrl.regw & w_condexr;
  assign MemWrite   = reset & r_ctrl.memw & w_condexr;
  assign AdrSrc     = r_ctrl.adrsrc;
  assign ResultSrc  = r_ctrl.resultsrc;
  assign ALUSrcA    = r_ctrl.alusrca;
  assign ALUSrcB    = r_ctrl.alusrcb;
  assign ALUControl = w_alu;
  assign ImmSrc     = w_op;
  assign RegSrc     = {w_op == c_op_mem, w_op == c_op_br};
  assign State      = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_retired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_retired <= '0;
    else if ((r_state == MEMWB) || (r_state == MEMWRITE) ||
             (r_state == ALUWB) || (r_state == BRANCH))
      r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign RetiredCount = r_retired;
`else
  localparam int c_unused_cnt_width = CNT_WIDTH;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : directed vector table, reset corner and randomized
// instruction stream against a behavioural instruction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] RetiredCount;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .State      (State)
`ifdef CTRL_PERF_CNT_EN
    ,
    .RetiredCount (RetiredCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ARM condition table over {N,Z,C,V}
  function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Runs one instruction from its FETCH cycle; expectations describe the final cycle
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int len,
                           input bit pl, input bit rw, input bit mw, input logic [1:0] alu);
    logic [1:0]  op;
    logic [15:0] act, exp;
    bit          last;
    logic [1:0]  e_rs, e_sb;
    op = ins[27:26];
    Instr = ins;
    ALUFlags = af;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c < 2)
        check($sformatf("state ins=%h c=%0d", ins, c), 32'(State), (c == 0) ? 32'(FETCH) : 32'(DECODE));
      last = (c == len - 1) && (c > 1);
      e_rs = (c < 2) ? 2'd2 : (op == 2'b10 && c == 2) ? 2'd2 : (op == 2'b01 && c == 4) ? 2'd1 : 2'd0;
      e_sb = (c < 2) ? 2'd2 :
             (c == 2 && (op == 2'b01 || op == 2'b10 || (op == 2'b00 && ins[25]))) ? 2'd1 : 2'd0;
      exp = {(c == 0) || (last && pl), c == 0, last && rw, last && mw,
             op == 2'b01 && c == 3, e_rs, c < 2, e_sb,
             (op == 2'b00 && c == 2) ? alu : 2'b00, op, op == 2'b01, op == 2'b10};
      act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegSrc};
      check($sformatf("ctrl ins=%h c=%0d", ins, c), 32'(act), 32'(exp));
      @(posedge clk);
      #1;
    end
    check($sformatf("boundary ins=%h", ins), 32'(State), 32'(FETCH));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(State), 32'(FETCH));
    check("reset strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  af;
    int          len;
    bit          pl;
    bit          rw;
    bit          mw;
    logic [1:0]  alu;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [3:0]  mflags;
    logic [31:0] ins;
    logic [3:0]  af;
    logic [1:0]  op, alu;
    bit          pass, isdp, isld, isst;
    int          len;

    tbl[0]  = '{32'hE0821003, 4'b0000, 4, 0, 1, 0, 2'b00}; // ADD R1,R2,R3
    tbl[1]  = '{32'hE2500001, 4'b0100, 4, 0, 1, 0, 2'b01}; // SUBS R0,R0,#1 -> Z
    tbl[2]  = '{32'h0A000002, 4'b0000, 3, 1, 0, 0, 2'b00}; // BEQ taken
    tbl[3]  = '{32'h1A000002, 4'b0000, 3, 0, 0, 0, 2'b00}; // BNE not taken
    tbl[4]  = '{32'hE5954008, 4'b0000, 5, 0, 1, 0, 2'b00}; // LDR
    tbl[5]  = '{32'hE5854008, 4'b0000, 4, 0, 0, 1, 2'b00}; // STR
    tbl[6]  = '{32'hF0921003, 4'b0000, 4, 0, 0, 0, 2'b00}; // ADDS cond=never
    tbl[7]  = '{32'h0A000002, 4'b0000, 3, 1, 0, 0, 2'b00}; // BEQ still taken
    tbl[8]  = '{32'hE082F003, 4'b0000, 4, 1, 1, 0, 2'b00}; // ADD PC
    tbl[9]  = '{32'hEC000000, 4'b0000, 2, 0, 0, 0, 2'b00}; // Op=11 no-op
    tbl[10] = '{32'hE0100000, 4'b1011, 4, 0, 1, 0, 2'b10}; // ANDS: N,Z only
    tbl[11] = '{32'h4A000002, 4'b0000, 3, 1, 0, 0, 2'b00}; // BMI taken
    tbl[12] = '{32'h2A000002, 4'b0000, 3, 0, 0, 0, 2'b00}; // BCS not taken
    tbl[13] = '{32'hE1821003, 4'b0000, 4, 0, 1, 0, 2'b11}; // ORR
    tbl[14] = '{32'hBA000002, 4'b0000, 3, 1, 0, 0, 2'b00}; // BLT taken
    tbl[15] = '{32'hCA000002, 4'b0000, 3, 0, 0, 0, 2'b00}; // BGT not taken

    do_reset();
    for (int i = 0; i < 16; i++)
      run_instr(tbl[i].ins, tbl[i].af, tbl[i].len, tbl[i].pl, tbl[i].rw, tbl[i].mw, tbl[i].alu);

    // Reset during MEMREAD, with Z set beforehand so clearing the flags is visible
    do_reset();
    run_instr(32'hE2500001, 4'b0100, 4, 0, 1, 0, 2'b01);
    Instr = 32'hE5954008;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("midreset pre state", 32'(State), 32'(MEMREAD));
    check("midreset pre adrsrc", 32'(AdrSrc), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("midreset state", 32'(State), 32'(FETCH));
    check("midreset strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
    @(posedge clk);
    #1;
    check("midreset held strobes", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
    reset = 1'b1;
    run_instr(32'h0A000002, 4'b0000, 3, 0, 0, 0, 2'b00); // flags cleared: BEQ falls through
    run_instr(32'h1A000002, 4'b0000, 3, 1, 0, 0, 2'b00);

`ifdef CTRL_PERF_CNT_EN
    do_reset();
    check("retired after reset", RetiredCount, 32'd0);
    run_instr(32'hE0821003, 4'b0000, 4, 0, 1, 0, 2'b00);
    run_instr(32'hE5854008, 4'b0000, 4, 0, 0, 1, 2'b00);
    run_instr(32'hEC000000, 4'b0000, 2, 0, 0, 0, 2'b00);
    run_instr(32'hEA000002, 4'b0000, 3, 1, 0, 0, 2'b00);
    check("retired count", RetiredCount, 32'd3);
`endif

    // Random instruction stream against an instruction-level model
    do_reset();
    mflags = 4'b0000;
    for (int k = 0; k < 80; k++) begin
      ins = $urandom;
      op = 2'($urandom_range(0, 3));
      ins[27:26] = op;
      af = 4'($urandom);
      pass = cond_ok(ins[31:28], mflags);
      isdp = (op == 2'b00);
      isld = (op == 2'b01) && ins[20];
      isst = (op == 2'b01) && !ins[20];
      len = (op == 2'b11) ? 2 : (op == 2'b10) ? 3 : isld ? 5 : 4;
      alu = isdp ? alu_of(ins[24:21]) : 2'b00;
      run_instr(ins, af, len,
                pass && ((op == 2'b10) || ((isdp || isld) && ins[15:12] == 4'hf)),
                pass && (isdp || isld), pass && isst, alu);
      if (isdp && pass && ins[20]) begin
        mflags[3:2] = af[3:2];
        if (alu == 2'b00 || alu == 2'b01)
          mflags[1:0] = af[1:0];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
